// File: rtl/nanov_spi_mem_arbiter.sv
// nanov_spi_mem_arbiter
// Two-port word-access arbiter in front of one SPI RAM/flash pin set.
// Each granted request is sent as command byte, ADDR_BITS address bits and
// 32 data bits, one bit per cycle. Data bytes go least significant byte
// first, and each byte is sent MSB first.
// Optional feature: define NANOV_SPI_ARB_FIXED_PRIORITY_EN to make port 0
// always win contention. The default is round-robin.
module nanov_spi_mem_arbiter #(
  parameter int ADDR_BITS = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 p0_req,
  input  logic                 p0_we,
  input  logic [ADDR_BITS-1:0] p0_addr,
  input  logic [31:0]          p0_wdata,
  output logic                 p0_ack,
  output logic [31:0]          p0_rdata,
  input  logic                 p1_req,
  input  logic                 p1_we,
  input  logic [ADDR_BITS-1:0] p1_addr,
  input  logic [31:0]          p1_wdata,
  output logic                 p1_ack,
  output logic [31:0]          p1_rdata,
  output logic                 spi_select,
  output logic                 spi_out,
  output logic                 spi_clk_enable,
  input  logic                 spi_data_in,
  output logic                 busy
);

  localparam int         FRAME_W   = 8 + ADDR_BITS + 32;
  localparam logic [5:0] ADDR_LAST = 6'(ADDR_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } state_t;

  state_t               state;
  logic [5:0]           bit_cnt;
  logic                 last_grant;
  logic                 gnt_port;
  logic                 gnt_we;
  logic [FRAME_W-1:0]   frame_sh;
  logic [31:0]          rx_sh;

  logic                 any_req;
  logic                 pick_p1;
  logic                 sel_we;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [31:0]          sel_wdata;
  logic [FRAME_W-1:0]   frame_load;
  logic [31:0]          rx_word;

  // The wire carries byte 0 first; this maps a word to wire order and back.
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  assign any_req = p0_req | p1_req;

`ifdef NANOV_SPI_ARB_FIXED_PRIORITY_EN
  assign pick_p1 = p1_req & ~p0_req;
`else
  // last_grant == 1 means port 1 was served last, so port 0 wins a tie.
  assign pick_p1 = p1_req & (~p0_req | ~last_grant);
`endif

  assign sel_we     = pick_p1 ? p1_we    : p0_we;
  assign sel_addr   = pick_p1 ? p1_addr  : p0_addr;
  assign sel_wdata  = pick_p1 ? p1_wdata : p0_wdata;
  // A read sends zeros on MOSI during the data phase.
  assign frame_load = {(sel_we ? 8'h02 : 8'h03), sel_addr,
                       (sel_we ? byte_swap(sel_wdata) : 32'h0)};
  assign rx_word    = byte_swap({rx_sh[30:0], spi_data_in});
  assign busy       = (state != ST_IDLE);

  // Transaction FSM: grant, count bit phases, drive pins, complete with an ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      bit_cnt        <= '0;
      last_grant     <= 1'b1;
      gnt_port       <= 1'b0;
      gnt_we         <= 1'b0;
      spi_select     <= 1'b1;
      spi_out        <= 1'b0;
      spi_clk_enable <= 1'b0;
      p0_ack         <= 1'b0;
      p1_ack         <= 1'b0;
      p0_rdata       <= '0;
      p1_rdata       <= '0;
    end else begin
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state          <= ST_CMD;
            bit_cnt        <= 6'd7;
            gnt_port       <= pick_p1;
            gnt_we         <= sel_we;
            spi_select     <= 1'b0;
            spi_clk_enable <= 1'b1;
            spi_out        <= frame_load[FRAME_W-1];
          end
        end
        ST_CMD: begin
          spi_out <= frame_sh[FRAME_W-1];
          if (bit_cnt == 6'd0) begin
            state   <= ST_ADDR;
            bit_cnt <= ADDR_LAST;
          end else begin
            bit_cnt <= bit_cnt - 6'd1;
          end
        end
        ST_ADDR: begin
          spi_out <= frame_sh[FRAME_W-1];
          if (bit_cnt == 6'd0) begin
            state   <= ST_DATA;
            bit_cnt <= 6'd31;
          end else begin
            bit_cnt <= bit_cnt - 6'd1;
          end
        end
        ST_DATA: begin
          if (bit_cnt == 6'd0) begin
            state          <= ST_DONE;
            spi_out        <= 1'b0;
            spi_select     <= 1'b1;
            spi_clk_enable <= 1'b0;
            if (gnt_port) begin
              p1_ack <= 1'b1;
              if (!gnt_we) p1_rdata <= rx_word;
            end else begin
              p0_ack <= 1'b1;
              if (!gnt_we) p0_rdata <= rx_word;
            end
          end else begin
            spi_out <= frame_sh[FRAME_W-1];
            bit_cnt <= bit_cnt - 6'd1;
          end
        end
        ST_DONE: begin
          state      <= ST_IDLE;
          last_grant <= gnt_port;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Frame and receive shifters: data only, so they are not reset.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE) begin
      if (any_req) frame_sh <= {frame_load[FRAME_W-2:0], 1'b0};
    end else if (state == ST_CMD || state == ST_ADDR ||
                 (state == ST_DATA && bit_cnt != 6'd0)) begin
      frame_sh <= {frame_sh[FRAME_W-2:0], 1'b0};
    end
    if (state == ST_DATA) rx_sh <= {rx_sh[30:0], spi_data_in};
  end

endmodule
